// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI bus arbiter: FSM states, requester and
// chip-select indices.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAssert,
    StXfer,
    StWait,
    StFinish,
    StAbort,
    StGap
  } arb_state_e;

  localparam int unsigned REQ_CFG  = 0;
  localparam int unsigned REQ_DATA = 1;

  localparam int unsigned CS0 = 0;
  localparam int unsigned CS1 = 1;

  // cs_n pattern {CS1, CS0} with only the selected slave driven low.
  function automatic logic [1:0] cs_low(input logic sel);
    logic [1:0] m;
    m = 2'b11;
    if (sel) m[CS1] = 1'b0;
    else     m[CS0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/spi_arb_rr.sv
// Two-way round-robin picker: a lone requester always wins; on contention the
// requester that did not own the bus last wins.
module spi_arb_rr
  import spi_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic [1:0] pick_o
);

  always_comb begin
    pick_o = req_i;
    if (req_i[REQ_CFG] && req_i[REQ_DATA]) begin
      pick_o = 2'b00;
      if (last_owner_i) pick_o[REQ_CFG]  = 1'b1;
      else              pick_o[REQ_DATA] = 1'b1;
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI master between the config engine and the tag-data path: grants whole
// transactions, drives the chip selects, sequences bytes and aborts on a per-byte timeout.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CS_GAP  = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic             sel0,
  input  logic             sel1,
  input  logic [7:0]       tx0,
  input  logic [7:0]       tx1,
  output logic [1:0]       gnt,
  output logic [1:0]       tx_take,
  output logic [7:0]       rx_data,
  output logic [1:0]       rx_valid,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic             m_start,
  output logic [7:0]       m_tx,
  input  logic             m_done,
  input  logic [7:0]       m_rx,
  output logic [1:0]       cs_n
);

  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
  localparam int unsigned GapW = $clog2(CS_GAP + 1);

  localparam logic [LEN_W-1:0] LenOne  = LEN_W'(1);
  localparam logic [WdW-1:0]   WdLoad  = WdW'(TIMEOUT);
  localparam logic [WdW-1:0]   WdOne   = WdW'(1);
  localparam logic [GapW-1:0]  GapLoad = GapW'(CS_GAP);
  localparam logic [GapW-1:0]  GapOne  = GapW'(1);

  arb_state_e       state_q;
  logic             owner_q;
  logic             prio_q;     // requester favoured on the next contended grant
  logic [LEN_W-1:0] cnt_q;
  logic [WdW-1:0]   wdog_q;
  logic [GapW-1:0]  gap_q;
  logic [1:0]       gnt_q;
  logic [1:0]       tx_take_q;
  logic [7:0]       rx_data_q;
  logic [1:0]       rx_valid_q;
  logic [1:0]       done_q;
  logic [1:0]       err_q;
  logic             m_start_q;
  logic [7:0]       m_tx_q;
  logic [1:0]       cs_n_q;

  logic [1:0]       pick;
  logic             pick_owner;
  logic [LEN_W-1:0] pick_len;
  logic             pick_sel;

  spi_arb_rr u_rr (
    .req_i        (req),
    .last_owner_i (~prio_q),
    .pick_o       (pick)
  );

  assign pick_owner = pick[REQ_DATA];
  assign pick_len   = pick_owner ? len1 : len0;
  assign pick_sel   = pick_owner ? sel1 : sel0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      wdog_q     <= '0;
      gap_q      <= '0;
      gnt_q      <= '0;
      tx_take_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= '0;
      done_q     <= '0;
      err_q      <= '0;
      m_start_q  <= 1'b0;
      m_tx_q     <= '0;
      cs_n_q     <= 2'b11;
    end else begin
      tx_take_q  <= '0;
      rx_valid_q <= '0;
      done_q     <= '0;
      err_q      <= '0;
      m_start_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            gnt_q   <= pick;
            owner_q <= pick_owner;
            cnt_q   <= pick_len;
            if (pick_len == '0) begin
              done_q  <= pick;
              state_q <= StFinish;
            end else begin
              cs_n_q  <= cs_low(pick_sel);
              state_q <= StAssert;
            end
          end
        end
        StAssert: state_q <= StXfer;
        StXfer: begin
          m_start_q          <= 1'b1;
          m_tx_q             <= owner_q ? tx1 : tx0;
          tx_take_q[owner_q] <= 1'b1;
          wdog_q             <= WdLoad;
          state_q            <= StWait;
        end
        StWait: begin
          if (m_done) begin
            rx_data_q           <= m_rx;
            rx_valid_q[owner_q] <= 1'b1;
            cnt_q               <= cnt_q - LenOne;
            if (cnt_q == LenOne) begin
              cs_n_q          <= 2'b11;
              done_q[owner_q] <= 1'b1;
              state_q         <= StFinish;
            end else begin
              state_q <= StXfer;
            end
          end else if (wdog_q <= WdOne) begin
            cs_n_q         <= 2'b11;
            err_q[owner_q] <= 1'b1;
            state_q        <= StAbort;
          end else begin
            wdog_q <= wdog_q - WdOne;
          end
        end
        StFinish, StAbort: begin
          gap_q   <= GapLoad;
          state_q <= StGap;
        end
        StGap: begin
          if (gap_q <= GapOne) begin
            gnt_q   <= '0;
            prio_q  <= ~owner_q;
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q - GapOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign tx_take  = tx_take_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign done     = done_q;
  assign err      = err_q;
  assign m_start  = m_start_q;
  assign m_tx     = m_tx_q;
  assign cs_n     = cs_n_q;

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares the single SPI master engine inside rfid_top between two internal requesters: req 0 is the config/register engine, req 1 is the tag-data path.
- Grants whole multi-byte transactions with round-robin fairness and owns the two active-low chip selects.
- Sequences byte transfers into the SPI master and enforces a minimum CS-high gap between transactions.
- Runs a per-byte watchdog; if the master never completes a byte, the transaction aborts and the bus frees.

Parameters:
- LEN_W, 4, width of transaction byte-count fields; max transaction is 2**LEN_W-1 bytes.
- CS_GAP, 4, minimum clk cycles both CS stay high between transactions (>=1).
- TIMEOUT, 1024, clk cycles to wait for m_done per byte before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  2  per-requester transaction request, level, held until done pulse
- len0 / len1  in  LEN_W  byte count for requester 0 / 1; sampled at grant
- sel0 / sel1  in  1  target slave for requester 0 / 1: 0 = CS0, 1 = CS1; sampled at grant
- tx0 / tx1  in  8  next transmit byte for requester 0 / 1
- gnt  out  2  one-hot grant, high for the whole transaction
- tx_take  out  2  1-cycle pulse: current tx byte consumed, present the next one
- rx_data  out  8  last received byte
- rx_valid  out  2  1-cycle pulse to the owner when rx_data is valid
- done  out  2  1-cycle pulse: owner's transaction finished normally
- err  out  2  1-cycle pulse: owner's transaction aborted by timeout
- m_start  out  1  1-cycle start to SPI master
- m_tx  out  8  byte to SPI master, valid with m_start
- m_done  in  1  SPI master byte-complete pulse
- m_rx  in  8  SPI master received byte, valid with m_done
- cs_n  out  2  active-low chip selects {CS1, CS0}

Behaviour:
- Reset values: gnt=0, tx_take=0, rx_valid=0, done=0, err=0, m_start=0, m_tx=0, rx_data=0, cs_n=2'b11, state=IDLE, rr pointer=0. Reset mid-transaction aborts immediately; no done/err pulse.
- States:
  - IDLE: if any req, grant by rr. Priority goes to the requester != last_owner when both request; a single requester wins regardless. Latch len/sel. If latched len==0, go to FINISH without touching CS. Otherwise go to ASSERT.
  - ASSERT: drive the selected cs_n bit low for one cycle (CS setup). Go to XFER.
  - XFER: pulse m_start with m_tx=tx[owner] and pulse tx_take[owner] the same cycle. Load the watchdog. Go to WAIT.
  - WAIT: on m_done, register rx_data=m_rx and pulse rx_valid[owner] the next cycle. Decrement the remaining count; if nonzero go to XFER, else go to FINISH. If the watchdog reaches 0 before m_done, go to ABORT. m_done arriving outside WAIT is ignored.
  - FINISH: cs_n=11, pulse done[owner], load the gap counter. Go to GAP.
  - ABORT: cs_n=11, pulse err[owner], load the gap counter. Go to GAP.
  - GAP: hold gnt until CS_GAP cycles have elapsed, then clear gnt, set last_owner=owner, go to IDLE.
- Grant is issued the cycle after req is seen in IDLE. A new grant cannot occur earlier than CS_GAP+1 cycles after cs_n returns high.
- Back-to-back bytes: next m_start is the cycle after the cycle that pulses rx_valid, so there is at least 1 idle cycle between m_done and the next m_start.
- Only one cs_n bit is ever low, and cs_n is never low outside ASSERT/XFER/WAIT.
- The owner dropping req mid-transaction is ignored; the transaction completes.
- len is counted modulo LEN_W bits; len==0 gives done with no SPI traffic and no CS activity.
- The watchdog counter is sized ceil(log2(TIMEOUT+1)) bits and reloads on every XFER.

Decomposition:
- Shared package spi_arb_pkg:
  - state enum (IDLE, ASSERT, XFER, WAIT, FINISH, ABORT, GAP)
  - requester index constants REQ_CFG=0, REQ_DATA=1
  - CS index constants
- One natural sub-module: spi_arb_rr, a 2-way round-robin picker (req[1:0], last_owner -> one-hot pick). The rest stays in the top FSM.

Test Plan:
- Single transfer: req0 with len0=2, sel0=0, tx0=A5 then 3C; master model echoes bytes inverted. Required: cs_n=10 during the transaction; m_tx sequence A5, 3C; rx_valid[0] twice with rx_data 5A, C3; done[0] once; cs_n=11 for at least 4 cycles before any new grant.
- Contention: req=11 from reset. Required: gnt=01 first. With both still requesting, the next grant is 10, then 01, strictly alternating over 6 transactions.
- Zero length: req1 with len1=0. Required: done[1] pulse, no m_start, cs_n stays 11 throughout.
- Timeout: req1 with len1=3, sel1=1; master never returns m_done. Required: err[1] exactly TIMEOUT cycles after m_start (±1); cs_n=11; no done[1]; req0 is then granted normally.
- Reset mid-operation: assert rst during WAIT of a 4-byte transaction. Required: next cycle gnt=0, cs_n=11, no done/err pulse; a fresh req0 afterwards completes correctly.
- Stray m_done while IDLE or GAP. Required: no rx_valid pulse and no state change.
